// File: rtl/imem_pkg.sv
// imem_pkg: shared instruction-memory geometry and loader state encoding for the loader and fetch.
package imem_pkg;
  localparam int IMEM_DEPTH = 16;
  localparam int IMEM_ADDR_W = 4;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RECV = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_CHECK = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;
  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    RECV  = ST_RECV,
    WRITE = ST_WRITE,
    CHECK = ST_CHECK,
    DONE  = ST_DONE
  } ld_state_e;
endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: collects 4 bytes little-endian into a 32-bit word, pulsing word_ready as the 4th byte is taken.
// Ports: clk, reset (sync, active-low), clr (drop partial word), en (byte taken), in_data,
// word (assembled word incl. current byte), word_ready (en on 4th byte).
module byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  in_data,
  output logic [31:0] word,
  output logic        word_ready
);
  logic [1:0] cnt_q, cnt_d;
  logic [23:0] sh_q, sh_d;
  assign word = {in_data, sh_q};
  assign word_ready = en && cnt_q == 2'd3;
  always_comb begin
    cnt_d = clr ? 2'd0 : en ? cnt_q + 2'd1 : cnt_q;
    sh_d = clr ? 24'd0 : en ? {in_data, sh_q[23:8]} : sh_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= 2'd0;
      sh_q <= 24'd0;
    end else begin
      cnt_q <= cnt_d;
      sh_q <= sh_d;
    end
  end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: loads a byte stream as little-endian words into instruction memory while holding the core.
// Ports: clk, reset (sync, active-low), start/num_words (begin load), in_valid/in_data/in_ready (byte stream),
// mem_we/mem_addr/mem_wdata (memory write), cpu_hold, done, csum_err.
// Optional macro IMEM_LOADER_CHECKSUM_EN adds a trailing 32-bit checksum check (CHECK state).
module imem_loader
  import imem_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH,
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              csum_err
);
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam ld_state_e FIN = CHECK;
`else
  localparam ld_state_e FIN = DONE;
`endif
  ld_state_e state_q, state_d;
  logic [ADDR_W:0] count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d, word;
  logic take, clr, word_ready, last;
  assign in_ready = state_q == RECV || state_q == CHECK;
  assign cpu_hold = state_q == RECV || state_q == WRITE || state_q == CHECK;
  assign mem_we = state_q == WRITE;
  assign done = state_q == DONE;
  assign mem_addr = addr_q;
  assign mem_wdata = wdata_q;
  assign take = in_valid && in_ready;
  assign clr = start && (state_q == IDLE || state_q == DONE);
  // the index stops at the last word instead of wrapping past DEPTH-1
  assign last = ({1'b0, addr_q} + (ADDR_W+1)'(1)) == count_q;
  byte_packer u_packer (
    .clk(clk),
    .reset(reset),
    .clr(clr),
    .en(take),
    .in_data(in_data),
    .word(word),
    .word_ready(word_ready)
  );
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE, DONE: if (start) begin
        count_d = num_words > (ADDR_W+1)'(DEPTH) ? (ADDR_W+1)'(DEPTH) : num_words;
        addr_d = '0;
        state_d = num_words == '0 ? FIN : RECV;
      end
      RECV: if (word_ready) begin
        wdata_d = word;
        state_d = WRITE;
      end
      WRITE: begin
        state_d = last ? FIN : RECV;
        addr_d = last ? addr_q : addr_q + 1'b1;
      end
      CHECK: if (word_ready) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
    end
  end
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] sum_q, sum_d;
  logic csum_err_q, csum_err_d;
  always_comb begin
    sum_d = clr ? 32'd0 : mem_we ? sum_q + wdata_q : sum_q;
    csum_err_d = clr ? 1'b0 : (state_q == CHECK && word_ready) ? word != sum_q : csum_err_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      sum_q <= 32'd0;
      csum_err_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      csum_err_q <= csum_err_d;
    end
  end
  assign csum_err = csum_err_q;
`else
  assign csum_err = 1'b0;
`endif
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized scoreboard bench for imem_loader against a queue-based load model.
module tb_imem_loader;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, in_valid = 1'b0;
  logic [4:0] num_words = '0;
  logic [7:0] in_data = '0;
  logic in_ready, mem_we, cpu_hold, done, csum_err;
  logic [3:0] mem_addr;
  logic [31:0] mem_wdata;
  int tests = 0, fails = 0, nwr = 0, cyc, wn;
  bit ir_seen, arm;
  time t0;
  logic [35:0] sb[$];
  logic [31:0] words[$];
  logic [35:0] e;
  imem_loader dut (
    .clk(clk), .reset(reset), .start(start), .num_words(num_words),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .done(done), .csum_err(csum_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (in_ready) ir_seen = 1'b1;
    if (reset && mem_we) begin
      nwr++;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got addr %0d data %h expected no write", mem_addr, mem_wdata);
      end else begin
        e = sb.pop_front();
        chk("write_addr", 32'(mem_addr), 32'(e[35:32]));
        chk("write_data", mem_wdata, e[31:0]);
      end
    end
  end
  task automatic send_byte(input logic [7:0] b, input int mode);
    int n = 0;
    if (mode == 2) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data = b;
    if (arm) begin t0 = $time; arm = 1'b0; end
    @(negedge clk);
    while (!in_ready && n < 100) begin n++; @(negedge clk); end
    if (!in_ready) chk("byte_accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (mode == 1) begin @(posedge clk); #1; end
  endtask
  task automatic load(input int nw, input int mode, input logic [31:0] bad, output int cycles, output int waits);
    int n = nw > 16 ? 16 : nw;
    logic [31:0] sum = 32'd0, w;
    while (words.size() < n) words.push_back($urandom);
    for (int i = 0; i < n; i++) begin
      sb.push_back({4'(i), words[i]});
      sum += words[i];
    end
    nwr = 0;
    ir_seen = 1'b0;
    arm = 1'b1;
    t0 = $time;
    start = 1'b1;
    num_words = 5'(nw);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      w = words[i];
      for (int k = 0; k < 4; k++) begin
        send_byte(w[8*k +: 8], mode);
        if (mode == 1 && i == 0 && k == 1) begin
          start = 1'b1;
          num_words = 5'd5;
          @(posedge clk); #1;
          start = 1'b0;
        end
      end
    end
    if (CS) begin
      sum += bad;
      for (int k = 0; k < 4; k++) send_byte(sum[8*k +: 8], mode);
    end
    waits = 0;
    do begin @(negedge clk); waits++; end while (!done && waits < 400);
    cycles = int'(($time - t0) / 10);
    chk("done", 32'(done), 32'd1);
    chk("cpu_hold_after_load", 32'(cpu_hold), 32'd0);
    chk("csum_err", 32'(csum_err), 32'(CS && bad != 0));
    chk("write_count", 32'(nwr), 32'(n));
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    words.delete();
    sb.delete();
    @(posedge clk); #1;
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_csum_err"}, 32'(csum_err), 32'd0);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_idle("reset");
    reset = 1'b1;
    @(posedge clk); #1;
    words.push_back(32'h0000_0013);
    words.push_back(32'h0010_0093);
    load(2, 0, 32'd0, cyc, wn);
    chk("two_word_cycles", 32'(cyc), CS ? 32'd14 : 32'd10);
    start = 1'b1;
    num_words = 5'd1;
    @(posedge clk); #1;
    start = 1'b0;
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_idle("mid_reset");
    reset = 1'b1;
    @(posedge clk); #1;
    load(1, 0, 32'd0, cyc, wn);
    load(0, 0, 32'd0, cyc, wn);
`ifndef IMEM_LOADER_CHECKSUM_EN
    chk("zero_done_latency", 32'(wn), 32'd1);
    chk("zero_in_ready_seen", 32'(ir_seen), 32'd0);
`endif
    load(20, 0, 32'd0, cyc, wn);
    in_valid = 1'b1;
    in_data = 8'h55;
    repeat (3) begin
      @(negedge clk);
      chk("no_accept_after_done", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("no_extra_write", 32'(nwr), 32'd16);
    words.push_back(32'hDEAD_BEEF);
    load(1, 1, 32'd0, cyc, wn);
`ifdef IMEM_LOADER_CHECKSUM_EN
    words.push_back(32'd1);
    words.push_back(32'd2);
    load(2, 0, 32'd0, cyc, wn);
    words.push_back(32'd1);
    words.push_back(32'd2);
    load(2, 0, 32'd1, cyc, wn);
`endif
    repeat (4) load(int'($urandom_range(1, 6)), 2, 32'd0, cyc, wn);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
